// File: rtl/hynoc_ingress_arbiter.sv
// hynoc_ingress_arbiter
//   Shares one hynoc router ingress port between NB_REQ local flit sources.
//   Arbitration is round-robin at packet granularity. A granted requester keeps
//   the port until its close flit (flit MSB = 1) is written. Writes are held off
//   while the router ingress FIFO level leaves fewer than FIFO_MARGIN free slots.
//
// Ports
//   clk                 single clock, shared with the router ingress write side
//   arst_n              asynchronous active-low reset
//   req_valid[i]        requester i presents a flit
//   req_data            flit of requester i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   req_ready[i]        flit of requester i consumed this cycle (combinational)
//   ingress_write       registered write strobe to the router ingress
//   ingress_data        registered flit to the router ingress
//   ingress_fifo_level  router ingress FIFO occupancy
//   grant               one-hot current owner, zero when idle
//
// Optional feature (macro HYNOC_INGRESS_ARB_PKTCNT_EN)
//   pkt_count_clr       synchronous clear of all packet counters
//   pkt_count           per-requester 16-bit saturating count of close flits
module hynoc_ingress_arbiter #(
   parameter int unsigned NB_REQ          = 4,
   parameter int unsigned LOG2_FIFO_DEPTH = 5,
   parameter int unsigned PAYLOAD_WIDTH   = 32,
   parameter int unsigned FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
   parameter int unsigned FIFO_MARGIN     = 2
) (
   input  logic                           clk,
   input  logic                           arst_n,
`ifdef HYNOC_INGRESS_ARB_PKTCNT_EN
   input  logic                           pkt_count_clr,
   output logic [NB_REQ*16-1:0]           pkt_count,
`endif
   input  logic [NB_REQ-1:0]              req_valid,
   input  logic [NB_REQ*FLIT_WIDTH-1:0]   req_data,
   output logic [NB_REQ-1:0]              req_ready,
   output logic                           ingress_write,
   output logic [FLIT_WIDTH-1:0]          ingress_data,
   input  logic [LOG2_FIFO_DEPTH:0]       ingress_fifo_level,
   output logic [NB_REQ-1:0]              grant
);

   localparam int unsigned PTR_W       = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
   localparam int unsigned LVL_W       = LOG2_FIFO_DEPTH + 1;
   localparam int unsigned SPACE_LIMIT = (2 ** LOG2_FIFO_DEPTH) - FIFO_MARGIN;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [NB_REQ-1:0]       grant_q, grant_d;
   logic [PTR_W-1:0]        gidx_q, gidx_d;
   logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic                    wr_q, wr_d;
   logic [FLIT_WIDTH-1:0]   data_q, data_d;

   logic                    space_c;
   logic                    owner_valid_c;
   logic [FLIT_WIDTH-1:0]   flit_c;
   logic                    xfer_c;
   logic                    close_xfer_c;
   logic                    pick_vld_c;
   logic [PTR_W-1:0]        pick_idx_c;
   logic [PTR_W-1:0]        rr_next_c;

   // Margin below full absorbs the level feedback latency.
   assign space_c = (ingress_fifo_level < LVL_W'(SPACE_LIMIT));

   // Owner's flit, selected through the one-hot grant.
   always_comb begin
      flit_c = '0;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         if (grant_q[i]) begin
            flit_c = flit_c | req_data[i*FLIT_WIDTH +: FLIT_WIDTH];
         end
      end
   end

   assign owner_valid_c = |(req_valid & grant_q);
   assign xfer_c        = (state_q == ST_LOCK) && owner_valid_c && space_c;
   assign close_xfer_c  = xfer_c && flit_c[FLIT_WIDTH-1];

   // First valid requester at or above rr_ptr, wrapping modulo NB_REQ.
   always_comb begin
      int unsigned idx;
      pick_vld_c = 1'b0;
      pick_idx_c = '0;
      idx        = 0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NB_REQ) begin
            idx = idx - NB_REQ;
         end
         if (!pick_vld_c && req_valid[PTR_W'(idx)]) begin
            pick_vld_c = 1'b1;
            pick_idx_c = PTR_W'(idx);
         end
      end
   end

   // Pointer moves past the owner that just closed.
   always_comb begin
      int unsigned nxt;
      nxt = 32'(gidx_q) + 1;
      if (nxt >= NB_REQ) begin
         nxt = 0;
      end
      rr_next_c = PTR_W'(nxt);
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      rr_ptr_d  = rr_ptr_q;
      wr_d      = 1'b0;
      data_d    = data_q;
      req_ready = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld_c) begin
               state_d = ST_LOCK;
               grant_d = NB_REQ'(1) << pick_idx_c;
               gidx_d  = pick_idx_c;
            end
         end
         ST_LOCK: begin
            req_ready = grant_q & req_valid & {NB_REQ{space_c}};
            if (xfer_c) begin
               wr_d   = 1'b1;
               data_d = flit_c;
               if (close_xfer_c) begin
                  state_d  = ST_IDLE;
                  grant_d  = '0;
                  rr_ptr_d = rr_next_c;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= '0;
         wr_q     <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         rr_ptr_q <= rr_ptr_d;
         wr_q     <= wr_d;
         data_q   <= data_d;
      end
   end

   assign grant         = grant_q;
   assign ingress_write = wr_q;
   assign ingress_data  = data_q;

`ifdef HYNOC_INGRESS_ARB_PKTCNT_EN
   localparam int unsigned CNT_W = 16;

   logic [NB_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Saturating per-requester close-flit counters; clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         if (pkt_count_clr) begin
            cnt_d[i] = '0;
         end else if (close_xfer_c && (gidx_q == PTR_W'(i)) && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_hynoc_ingress_arbiter.sv
// Testbench for hynoc_ingress_arbiter (default parameters: 4 requesters,
// 32-deep ingress FIFO, 33-bit flits, margin 2). Inputs are driven on the
// falling edge and outputs sampled 1 time unit later.
module tb_hynoc_ingress_arbiter;

   localparam int unsigned NB = 4;
   localparam int unsigned FW = 33;
   localparam int unsigned LW = 6;

   logic               clk = 1'b0;
   logic               arst_n;
   logic [NB-1:0]      req_valid;
   logic [NB*FW-1:0]   req_data;
   logic [NB-1:0]      req_ready;
   logic               ingress_write;
   logic [FW-1:0]      ingress_data;
   logic [LW-1:0]      ingress_fifo_level;
   logic [NB-1:0]      grant;
`ifdef HYNOC_INGRESS_ARB_PKTCNT_EN
   logic               pkt_count_clr;
   logic [NB*16-1:0]   pkt_count;
`endif

   int errors = 0;
   int checks = 0;

   hynoc_ingress_arbiter dut (
      .clk                (clk),
      .arst_n             (arst_n),
`ifdef HYNOC_INGRESS_ARB_PKTCNT_EN
      .pkt_count_clr      (pkt_count_clr),
      .pkt_count          (pkt_count),
`endif
      .req_valid          (req_valid),
      .req_data           (req_data),
      .req_ready          (req_ready),
      .ingress_write      (ingress_write),
      .ingress_data       (ingress_data),
      .ingress_fifo_level (ingress_fifo_level),
      .grant              (grant)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [NB-1:0]          v;
      logic [NB-1:0][FW-1:0]  f;
      logic [LW-1:0]          lvl;
      logic [NB-1:0]          e_grant;
      logic [NB-1:0]          e_ready;
      logic                   e_wr;
      logic [FW-1:0]          e_data;
   } vec_t;

   vec_t tbl[$];

   localparam logic [FW-1:0] Z   = '0;
   localparam logic [FW-1:0] HDR = {1'b0, 32'h0000_0AB2};
   localparam logic [FW-1:0] CLS = {1'b1, 32'hCAFE_DECA};
   localparam logic [FW-1:0] A1  = {1'b0, 32'h11};
   localparam logic [FW-1:0] A2  = {1'b0, 32'h12};
   localparam logic [FW-1:0] A3  = {1'b1, 32'h13};
   localparam logic [FW-1:0] B1  = {1'b0, 32'h31};
   localparam logic [FW-1:0] B2  = {1'b0, 32'h32};
   localparam logic [FW-1:0] B3  = {1'b1, 32'h33};
   localparam logic [FW-1:0] C0  = {1'b1, 32'h40};
   localparam logic [FW-1:0] D0  = {1'b1, 32'h50};
   localparam logic [FW-1:0] E1  = {1'b0, 32'h61};
   localparam logic [FW-1:0] E2  = {1'b0, 32'h62};
   localparam logic [FW-1:0] E3  = {1'b1, 32'h63};
   localparam logic [FW-1:0] F0  = {1'b1, 32'h70};
   localparam logic [FW-1:0] G1  = {1'b0, 32'h81};
   localparam logic [FW-1:0] G2  = {1'b0, 32'h82};
   localparam logic [FW-1:0] G3  = {1'b0, 32'h83};
   localparam logic [FW-1:0] H1  = {1'b0, 32'h91};
   localparam logic [FW-1:0] H2  = {1'b1, 32'h92};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] v, input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                      input logic [FW-1:0] f2, input logic [FW-1:0] f3, input logic [LW-1:0] lvl,
                      input logic [3:0] eg, input logic [3:0] er, input logic ew,
                      input logic [FW-1:0] ed);
      vec_t t;
      t.v = v;
      t.f[0] = f0;
      t.f[1] = f1;
      t.f[2] = f2;
      t.f[3] = f3;
      t.lvl = lvl;
      t.e_grant = eg;
      t.e_ready = er;
      t.e_wr = ew;
      t.e_data = ed;
      tbl.push_back(t);
   endtask

   task automatic set_flit(input int i, input logic [FW-1:0] f);
      req_data[i*FW +: FW] = f;
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_n             = 1'b0;
      req_valid          = '0;
      req_data           = '0;
      ingress_fifo_level = '0;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
   endtask

   // Fairness model state
   int             m_own;
   int             m_rr;
   int             fidx[3];
   int             m_pkts[3];
   int             obs_pkts[3];
   logic           m_wr;
   logic [FW-1:0]  m_data;
   logic [FW-1:0]  cur_flit;
   logic [NB-1:0]  e_g;
   int             mx;
   int             mn;

   initial begin
      arst_n             = 1'b0;
      req_valid          = 4'b1111;
      req_data           = '0;
      ingress_fifo_level = '0;
`ifdef HYNOC_INGRESS_ARB_PKTCNT_EN
      pkt_count_clr      = 1'b0;
`endif

      // Reset held with all requesters valid
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rst%0d wr", i), 64'(ingress_write), 64'(0));
         chk($sformatf("rst%0d grant", i), 64'(grant), 64'(0));
         chk($sformatf("rst%0d ready", i), 64'(req_ready), 64'(0));
      end
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      chk("rel grant idle", 64'(grant), 64'(0));
      @(negedge clk);
      #1;
      chk("rel first grant", 64'(grant), 64'(4'b0001));
      req_valid = '0;

      // Directed table: single packet, contention, single-flit packets,
      // in-packet gap, backpressure at the FIFO threshold
      add(4'b0001, HDR, Z,  Z,  Z,  0,  4'b0000, 4'b0000, 0, Z);
      add(4'b0001, HDR, Z,  Z,  Z,  0,  4'b0001, 4'b0001, 0, Z);
      add(4'b0001, CLS, Z,  Z,  Z,  0,  4'b0001, 4'b0001, 1, HDR);
      add(4'b0000, Z,   Z,  Z,  Z,  0,  4'b0000, 4'b0000, 1, CLS);
      add(4'b0000, Z,   Z,  Z,  Z,  0,  4'b0000, 4'b0000, 0, CLS);
      add(4'b1010, Z,   A1, Z,  B1, 0,  4'b0000, 4'b0000, 0, CLS);
      add(4'b1010, Z,   A1, Z,  B1, 0,  4'b0010, 4'b0010, 0, CLS);
      add(4'b1010, Z,   A2, Z,  B1, 0,  4'b0010, 4'b0010, 1, A1);
      add(4'b1010, Z,   A3, Z,  B1, 0,  4'b0010, 4'b0010, 1, A2);
      add(4'b1000, Z,   Z,  Z,  B1, 0,  4'b0000, 4'b0000, 1, A3);
      add(4'b1000, Z,   Z,  Z,  B1, 0,  4'b1000, 4'b1000, 0, A3);
      add(4'b1000, Z,   Z,  Z,  B2, 0,  4'b1000, 4'b1000, 1, B1);
      add(4'b0000, Z,   Z,  Z,  Z,  0,  4'b1000, 4'b0000, 1, B2);
      add(4'b1000, Z,   Z,  Z,  B3, 0,  4'b1000, 4'b1000, 0, B2);
      add(4'b0000, Z,   Z,  Z,  Z,  0,  4'b0000, 4'b0000, 1, B3);
      add(4'b0000, Z,   Z,  Z,  Z,  0,  4'b0000, 4'b0000, 0, B3);
      add(4'b0011, C0,  D0, Z,  Z,  0,  4'b0000, 4'b0000, 0, B3);
      add(4'b0011, C0,  D0, Z,  Z,  0,  4'b0001, 4'b0001, 0, B3);
      add(4'b0010, Z,   D0, Z,  Z,  0,  4'b0000, 4'b0000, 1, C0);
      add(4'b0010, Z,   D0, Z,  Z,  0,  4'b0010, 4'b0010, 0, C0);
      add(4'b0000, Z,   Z,  Z,  Z,  0,  4'b0000, 4'b0000, 1, D0);
      add(4'b0100, Z,   Z,  E1, Z,  0,  4'b0000, 4'b0000, 0, D0);
      add(4'b0100, Z,   Z,  E1, Z,  0,  4'b0100, 4'b0100, 0, D0);
      add(4'b0100, Z,   Z,  E2, Z,  30, 4'b0100, 4'b0000, 1, E1);
      add(4'b0101, F0,  Z,  E2, Z,  30, 4'b0100, 4'b0000, 0, E1);
      add(4'b0101, F0,  Z,  E2, Z,  29, 4'b0100, 4'b0100, 0, E1);
      add(4'b0101, F0,  Z,  E3, Z,  29, 4'b0100, 4'b0100, 1, E2);
      add(4'b0001, F0,  Z,  Z,  Z,  0,  4'b0000, 4'b0000, 1, E3);
      add(4'b0001, F0,  Z,  Z,  Z,  0,  4'b0001, 4'b0001, 0, E3);
      add(4'b0000, Z,   Z,  Z,  Z,  0,  4'b0000, 4'b0000, 1, F0);

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         req_valid          = tbl[i].v;
         req_data           = tbl[i].f;
         ingress_fifo_level = tbl[i].lvl;
         #1;
         chk($sformatf("v%0d grant", i), 64'(grant), 64'(tbl[i].e_grant));
         chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
         chk($sformatf("v%0d wr", i), 64'(ingress_write), 64'(tbl[i].e_wr));
         chk($sformatf("v%0d data", i), 64'(ingress_data), 64'(tbl[i].e_data));
      end

      // Fairness: requesters 0..2 stream 2-flit packets against a small model
      do_reset();
      m_own = -1;
      m_rr = 0;
      m_wr = 1'b0;
      m_data = '0;
      for (int i = 0; i < 3; i++) begin
         fidx[i] = 0;
         m_pkts[i] = 0;
         obs_pkts[i] = 0;
      end
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         req_valid = 4'b0111;
         for (int i = 0; i < 3; i++) begin
            set_flit(i, {(fidx[i] == 1), 32'(i * 16 + fidx[i])});
         end
         set_flit(3, Z);
         #1;
         e_g = (m_own >= 0) ? (NB'(1) << m_own) : '0;
         chk($sformatf("fair%0d grant", c), 64'(grant), 64'(e_g));
         chk($sformatf("fair%0d ready", c), 64'(req_ready), 64'(e_g));
         chk($sformatf("fair%0d wr", c), 64'(ingress_write), 64'(m_wr));
         chk($sformatf("fair%0d data", c), 64'(ingress_data), 64'(m_data));
         if (ingress_write && ingress_data[FW-1]) begin
            for (int i = 0; i < 3; i++) begin
               if (ingress_data[31:0] == 32'(i * 16 + 1)) obs_pkts[i]++;
            end
         end
         // advance model to the next cycle
         m_wr = 1'b0;
         if (m_own < 0) begin
            for (int k = 0; k < 4; k++) begin
               if (m_own < 0 && ((m_rr + k) % 4) < 3) m_own = (m_rr + k) % 4;
            end
         end else begin
            cur_flit = {(fidx[m_own] == 1), 32'(m_own * 16 + fidx[m_own])};
            m_wr = 1'b1;
            m_data = cur_flit;
            if (cur_flit[FW-1]) begin
               m_pkts[m_own]++;
               m_rr = (m_own + 1) % 4;
               fidx[m_own] = 0;
               m_own = -1;
            end else begin
               fidx[m_own] = 1;
            end
         end
      end
      mx = obs_pkts[0];
      mn = obs_pkts[0];
      for (int i = 1; i < 3; i++) begin
         if (obs_pkts[i] > mx) mx = obs_pkts[i];
         if (obs_pkts[i] < mn) mn = obs_pkts[i];
      end
      chk("fair min pkts", 64'(mn >= 6), 64'(1));
      chk("fair spread", 64'((mx - mn) <= 1), 64'(1));
`ifdef HYNOC_INGRESS_ARB_PKTCNT_EN
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("fair cnt%0d", i), 64'(pkt_count[i*16 +: 16]), 64'(m_pkts[i]));
      end
`endif

      // Reset in the middle of a 4-flit packet from requester 2
      do_reset();
      @(negedge clk);
      req_valid = 4'b0100;
      set_flit(2, G1);
      #1;
      chk("mid grant idle", 64'(grant), 64'(0));
      @(negedge clk);
      #1;
      chk("mid grant", 64'(grant), 64'(4'b0100));
      chk("mid ready", 64'(req_ready), 64'(4'b0100));
      @(negedge clk);
      set_flit(2, G2);
      #1;
      chk("mid wr g1", 64'(ingress_write), 64'(1));
      chk("mid data g1", 64'(ingress_data), 64'(G1));
      @(negedge clk);
      set_flit(2, G3);
      arst_n = 1'b0;
      #1;
      chk("mid rst grant", 64'(grant), 64'(0));
      chk("mid rst wr", 64'(ingress_write), 64'(0));
      chk("mid rst ready", 64'(req_ready), 64'(0));
      chk("mid rst data", 64'(ingress_data), 64'(0));
      @(negedge clk);
      arst_n = 1'b1;
      set_flit(2, H1);
      #1;
      chk("post grant idle", 64'(grant), 64'(0));
`ifdef HYNOC_INGRESS_ARB_PKTCNT_EN
      chk("post cnt2 partial", 64'(pkt_count[2*16 +: 16]), 64'(0));
`endif
      @(negedge clk);
      #1;
      chk("post grant", 64'(grant), 64'(4'b0100));
      chk("post ready", 64'(req_ready), 64'(4'b0100));
      @(negedge clk);
      set_flit(2, H2);
      #1;
      chk("post wr h1", 64'(ingress_write), 64'(1));
      chk("post data h1", 64'(ingress_data), 64'(H1));
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("post close grant", 64'(grant), 64'(0));
      chk("post data h2", 64'(ingress_data), 64'(H2));
`ifdef HYNOC_INGRESS_ARB_PKTCNT_EN
      chk("post cnt2 full", 64'(pkt_count[2*16 +: 16]), 64'(1));
      @(negedge clk);
      pkt_count_clr = 1'b1;
      @(negedge clk);
      pkt_count_clr = 1'b0;
      #1;
      chk("cnt clr", 64'(pkt_count), 64'(0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hynoc_ingress_arbiter.md
Name: hynoc_ingress_arbiter

Overview:
- Shares one hynoc router ingress port between NB_REQ local flit sources (DMA, CPU mailbox, test injectors).
- Round-robin arbitration at packet granularity: once granted, a requester keeps the port until its close flit (flit MSB = 1) is written.
- Flow control comes from the router's ingress FIFO level.
- Drives the router's portN_ingress_write/portN_ingress_data directly.

Parameters:
- NB_REQ, 4, number of requesters (2..8).
- LOG2_FIFO_DEPTH, 5, log2 of the router ingress FIFO depth.
- PAYLOAD_WIDTH, 32, flit payload width.
- FLIT_WIDTH, PAYLOAD_WIDTH+1, flit width; MSB is the close flag.
- FIFO_MARGIN, 2, free FIFO slots reserved to absorb level-feedback latency (1..2**LOG2_FIFO_DEPTH-1).

Ports:
- clk, in, 1, single clock; shared with the router ingress write side.
- arst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NB_REQ, requester i presents a flit.
- req_data, in, NB_REQ*FLIT_WIDTH, flits; requester i at bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- req_ready, out, NB_REQ, flit of requester i consumed this cycle.
- ingress_write, out, 1, write strobe to router ingress.
- ingress_data, out, FLIT_WIDTH, flit to router ingress.
- ingress_fifo_level, in, LOG2_FIFO_DEPTH+1, router ingress FIFO occupancy.
- grant, out, NB_REQ, one-hot current owner; all zero when idle.

Behaviour:
- Reset (arst_n=0, asynchronous): state=IDLE, grant=0, rr_ptr=0, ingress_write=0, ingress_data=0, req_ready=0.
- space = (ingress_fifo_level < 2**LOG2_FIFO_DEPTH - FIFO_MARGIN), combinational.
- IDLE state:
  - If any req_valid is set, select the first valid index searching upward from rr_ptr, wrapping modulo NB_REQ.
  - Register grant for that index and go to LOCK.
  - No transfer happens in IDLE.
- LOCK state:
  - req_ready[g] = req_valid[g] & space (combinational); other ready bits are 0.
  - On transfer (req_valid[g] & req_ready[g]): next cycle ingress_write=1 and ingress_data=flit (1-cycle registered latency).
  - Otherwise ingress_write=0 and ingress_data holds its last value.
- Close flit: a transfer with flit[FLIT_WIDTH-1]=1 sets state=IDLE, grant=0, rr_ptr=(g+1) mod NB_REQ. The next arbitration happens the following cycle, so there is a minimum 1-cycle bubble between packets.
- A single-flit packet (first flit is a close flit) is legal; it holds the lock for exactly one transfer.
- Gaps inside a packet: the lock is held indefinitely while req_valid[g]=0. Flits of different requesters are never interleaved.
- space=0 while locked: transfers stall and the lock is held. Level-feedback latency of up to FIFO_MARGIN-1 cycles never overflows the FIFO.
- Requests arriving while locked wait and have no effect on the current owner.
- Requester contract: req_valid/req_data are held stable until req_ready. The arbiter does not check this.
- Reset mid-packet: everything returns to reset values immediately. The partial packet is not closed; upstream reset handles recovery.
- rr_ptr updates only on close, so a requester sending back-to-back packets yields to any other pending requester.

Optional Feature:
- Macro HYNOC_INGRESS_ARB_PKTCNT_EN.
- When defined:
  - Adds output pkt_count[NB_REQ*16-1:0]: per-requester 16-bit counter of close flits transferred.
  - Counters saturate at 16'hFFFF and reset to 0 on arst_n.
  - Adds input pkt_count_clr (1 bit): synchronous clear of all counters. When clear coincides with an increment, clear wins.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset: hold arst_n=0 for 3 clk with req_valid=4'b1111 -> ingress_write=0, grant=0, req_ready=0 throughout; first grant=4'b0001 one cycle after arst_n rises.
- Single packet: req0 sends {0,hdr 0x00000AB2}, then {1,32'hCAFEDECA}, level=0 -> ingress_write high 2 consecutive cycles with those flits; grant=0 the cycle after close.
- Contention: req1 and req3 valid together, 3-flit packets, rr_ptr=0 -> all req1 flits out, 1 idle cycle, then all req3 flits; no interleave; rr_ptr ends at 0.
- Fairness: req0, req1, req2 continuously sending 2-flit packets for 60 cycles -> grant order 0,1,2,0,1,2...; packet counts differ by at most 1.
- Backpressure: LOG2_FIFO_DEPTH=5, FIFO_MARGIN=2, level forced to 30 mid-packet -> req_ready=0 and no write; level 29 -> transfers resume in the same cycle.
- Reset mid-packet: assert arst_n=0 after flit 2 of 4 -> grant=0 and ingress_write=0 at once; after release req2 is granted fresh from rr_ptr=0. With HYNOC_INGRESS_ARB_PKTCNT_EN: count unchanged by the partial packet, then 1 after a complete packet.
